load_store_unit: RTL and testbench

//  Memory stage directly downstream of the ALU. Takes the ALU result as the effective address
//  for LB/LH/LW/LBU/LHU/SB/SH/SW and runs one data-memory transaction over a req/ready handshake.

---
 rtl/load_store_unit_pkg.sv | 24 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit:
// funct3 access sizes, FSM states and response kinds.
package load_store_unit_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    RSP_LOAD,
    RSP_STORE,
    RSP_MISAL,
    RSP_BUS
  } lsu_rsp_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: misalign check, byte enables and store
// replication on the request side, load extraction on the response side.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [31:0] x;

  always_comb begin
    misalign_o = 1'b1;
    be_o       = 4'b0000;
    wdata_o    = st_wdata_i;
    unique case (st_funct3_i)
      LS_B, LS_BU: begin
        misalign_o = 1'b0;
        be_o       = 4'b0001 << st_off_i;
        wdata_o    = {4{st_wdata_i[7:0]}};
      end
      LS_H, LS_HU: begin
        misalign_o = st_off_i[0];
        be_o       = 4'b0011 << st_off_i;
        wdata_o    = {2{st_wdata_i[15:0]}};
      end
      LS_W: begin
        misalign_o = |st_off_i;
        be_o       = 4'b1111;
      end
      default: ;
    endcase
  end

  assign x = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ldata_o = x;
    unique case (ld_funct3_i)
      LS_B:    ldata_o = {{24{x[7]}}, x[7:0]};
      LS_BU:   ldata_o = {24'd0, x[7:0]};
      LS_H:    ldata_o = {{16{x[15]}}, x[15:0]};
      LS_HU:   ldata_o = {16'd0, x[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one data-memory transaction per op over req/ready,
// with misalign and bus-timeout exceptions.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_we,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [4:0]        in_rd,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              st_done,
  output logic              exc_misalign,
  output logic              exc_bus
);

  localparam logic [15:0] WaitMax = 16'(MAX_WAIT);

  lsu_state_e        state_q, state_d;
  lsu_rsp_e          rsp_q, rsp_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       wb_data_q;
  logic [4:0]        wb_rd_q;
  logic              accept;
  logic              capture;
  logic              misalign;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       ldata;
  logic              in_resp;

  lsu_align u_align (
    .st_funct3_i (in_funct3),
    .st_off_i    (in_addr[1:0]),
    .st_wdata_i  (in_wdata),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (mem_rdata),
    .misalign_o  (misalign),
    .be_o        (be),
    .wdata_o     (wdata),
    .ldata_o     (ldata)
  );

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      LSU_REQ: begin
        cnt_d = cnt_q + 16'd1;
        // A late ready still wins over the timeout
        if (mem_ready) begin
          capture = 1'b1;
          state_d = LSU_RESP;
          rsp_d   = we_q ? RSP_STORE : RSP_LOAD;
        end else if (cnt_d == WaitMax) begin
          state_d = LSU_RESP;
          rsp_d   = RSP_BUS;
        end
      end
      default: begin
        state_d = LSU_IDLE;
        if (in_valid) begin
          accept = 1'b1;
          cnt_d  = '0;
          if (misalign) begin
            state_d = LSU_RESP;
            rsp_d   = RSP_MISAL;
          end else begin
            state_d = LSU_REQ;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LSU_IDLE;
      rsp_q     <= RSP_LOAD;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      rd_q      <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= in_we;
        f3_q    <= in_funct3;
        off_q   <= in_addr[1:0];
        rd_q    <= in_rd;
        addr_q  <= {in_addr[ADDR_W-1:2], 2'b00};
        be_q    <= be;
        wdata_q <= wdata;
      end
      if (capture && !we_q) begin
        wb_data_q <= ldata;
        wb_rd_q   <= rd_q;
      end else if (state_d == LSU_RESP) begin
        wb_data_q <= '0;
      end
    end
  end

  assign in_resp      = (state_q == LSU_RESP);
  assign busy         = (state_q == LSU_REQ);
  assign mem_req      = busy;
  assign mem_we       = busy & we_q;
  assign mem_addr     = addr_q;
  assign mem_be       = be_q;
  assign mem_wdata    = wdata_q;
  assign wb_valid     = in_resp && (rsp_q == RSP_LOAD);
  assign st_done      = in_resp && (rsp_q == RSP_STORE);
  assign exc_misalign = in_resp && (rsp_q == RSP_MISAL);
  assign exc_bus      = in_resp && (rsp_q == RSP_BUS);
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases then random ops against
// an arithmetic model with a randomly delayed memory responder.
module tb_load_store_unit;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_we = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [4:0]  in_rd = '0;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        st_done;
  logic        exc_misalign;
  logic        exc_bus;

  int vecs = 0;
  int errs = 0;

  load_store_unit #(.ADDR_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_we(in_we), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_done(st_done), .exc_misalign(exc_misalign), .exc_bus(exc_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic run_op(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input int dly,
                        input logic [31:0] rdata);
    int sz, off;
    bit mis, bus;
    logic [3:0]  ebe;
    logic [31:0] ewd, eld, x;
    off = int'(addr % 4);
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    mis = (sz == 0) || ((addr % sz) != 0);
    ebe = '0;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + sz) ebe[i] = 1'b1;
    ewd = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
          (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    x = rdata >> (8 * off);
    case (f3)
      3'd0:    eld = (x & 32'hFF) - (((x & 32'h80) != 0) ? 32'h100 : 32'h0);
      3'd4:    eld = x & 32'hFF;
      3'd1:    eld = (x & 32'hFFFF) - (((x & 32'h8000) != 0) ? 32'h10000 : 32'h0);
      3'd5:    eld = x & 32'hFFFF;
      default: eld = x;
    endcase
    in_valid = 1'b1; in_we = we; in_funct3 = f3;
    in_addr = addr; in_wdata = wd; in_rd = rd;
    @(negedge clk);
    in_valid = 1'b0;
    if (mis) begin
      check("misal_pulse", exc_misalign, 1);
      check("misal_noreq", mem_req, 0);
      check("misal_busy", busy, 0);
      check("misal_wbdata", wb_data, 0);
      return;
    end
    bus = 0;
    for (int n = 0; n <= MW; n++) begin
      check("req", mem_req, 1);
      check("busy", busy, 1);
      check("mem_we", mem_we, we);
      check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      check("mem_be", mem_be, ebe);
      if (we) check("mem_wdata", mem_wdata, ewd);
      mem_ready = (n == dly);
      mem_rdata = mem_ready ? rdata : $urandom;
      @(negedge clk);
      mem_ready = 1'b0;
      if (n == dly) break;
      if (n == MW - 1) begin
        bus = 1;
        break;
      end
    end
    check("resp_noreq", mem_req, 0);
    check("resp_busy", busy, 0);
    check("wb_valid", wb_valid, !bus && !we);
    check("st_done", st_done, !bus && we);
    check("exc_bus", exc_bus, bus);
    check("exc_misalign", exc_misalign, 0);
    if (!bus && !we) begin
      check("wb_data", wb_data, eld);
      check("wb_rd", wb_rd, rd);
    end else begin
      check("wb_data_zero", wb_data, 0);
    end
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [2:0]  ld_set [5];
    logic [2:0]  bad_set [3];
    ld_set  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bad_set = '{3'd3, 3'd6, 3'd7};

    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_be", mem_be, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_pulses", {wb_valid, st_done, exc_misalign, exc_bus}, 0);
    check("rst_wb", {27'd0, wb_rd} | wb_data, 0);
    rst = 1'b0;

    run_op(1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0);
    run_op(0, 3'd0, 32'h203, 0, 5'd5, 0, 32'h80AABBCC);
    run_op(0, 3'd4, 32'h203, 0, 5'd6, 1, 32'h80AABBCC);
    run_op(0, 3'd1, 32'h202, 0, 5'd7, 0, 32'h7FFF1234);
    run_op(0, 3'd1, 32'h201, 0, 5'd7, 0, 32'h7FFF1234);
    run_op(1, 3'd0, 32'h41, 32'h000000A5, 5'd0, 3, 0);
    run_op(0, 3'd2, 32'h400, 0, 5'd9, 1000, 32'h12345678);
    run_op(0, 3'd3, 32'h500, 0, 5'd1, 0, 0);

    // Reset in the middle of a request
    in_valid = 1'b1; in_we = 1'b0; in_funct3 = 3'd2;
    in_addr = 32'h300; in_rd = 5'd3;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_drop_req", mem_req, 0);
    check("rst_drop_busy", busy, 0);
    @(negedge clk);
    check("rst_no_pulse", {wb_valid, st_done, exc_misalign, exc_bus}, 0);
    rst = 1'b0;
    run_op(0, 3'd2, 32'h304, 0, 5'd3, 1, 32'hCAFEF00D);

    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      we = 1'($urandom % 2);
      if ($urandom % 10 == 0) f3 = bad_set[$urandom % 3];
      else if (we) f3 = ld_set[$urandom % 3];
      else f3 = ld_set[$urandom % 5];
      run_op(we, f3, $urandom, $urandom, 5'($urandom),
             $urandom_range(0, 5), $urandom);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
